// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller for the five-stage RISC-V core.
//            Produces stall/flush controls for the F/D/E/M stage registers and
//            operand-forwarding selects for the execute ALU. A three-state
//            FSM sequences boot flushing, load-use bubbles and data-memory
//            wait freezes, with a sticky memory-timeout watchdog.
//            Optional macro HAZARD_PERF_EN adds saturating stall/flush
//            performance counters (o_stall_cnt, o_flush_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int BOOT_CYCLES = 2,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  i_rs1_d,
   input  logic [4:0]  i_rs2_d,
   input  logic [4:0]  i_rs1_e,
   input  logic [4:0]  i_rs2_e,
   input  logic [4:0]  i_rd_e,
   input  logic        i_load_e,
   input  logic        i_pcsrc_e,
   input  logic [4:0]  i_rd_m,
   input  logic        i_regwrite_m,
   input  logic        i_memreq_m,
   input  logic        i_dmem_ready,
   input  logic [4:0]  i_rd_w,
   input  logic        i_regwrite_w,
   output logic        o_stall_f,
   output logic        o_stall_d,
   output logic        o_stall_e,
   output logic        o_stall_m,
   output logic        o_flush_d,
   output logic        o_flush_e,
   output logic [1:0]  o_fwd_a_e,
   output logic [1:0]  o_fwd_b_e,
   output logic        o_mem_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] o_stall_cnt,
   output logic [31:0] o_flush_cnt
`endif
);

   // Boot counter runs 0 .. BOOT_CYCLES-1; a zero setting still gives one boot cycle.
   localparam int c_BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [c_BOOT_W-1:0] c_BOOT_LAST =
      c_BOOT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);

   // Timeout counter saturates at MEM_TIMEOUT.
   localparam int c_TO_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      S_BOOT     = 2'd0,
      S_RUN      = 2'd1,
      S_MEM_WAIT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_BOOT_W-1:0] r_boot_cnt;
   logic [c_TO_W-1:0]   r_to_cnt;
   logic [c_TO_W-1:0]   w_to_nxt;
   logic                r_mem_err;
   logic                w_load_use;
   logic                w_freeze;

   // Load-use: the load in E targets a source of the instruction in D (x0 excluded).
   assign w_load_use = i_load_e & (i_rd_e != 5'd0) &
                       ((i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d));

   // Pipeline is frozen while the memory stage waits on a not-ready data memory.
   assign w_freeze = ~i_dmem_ready &
                     ((r_state == S_MEM_WAIT) | ((r_state == S_RUN) & i_memreq_m));

   // Saturating increment of the not-ready counter while waiting.
   assign w_to_nxt = (r_to_cnt == c_TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;

   // State register, boot/timeout counters and sticky error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_BOOT;
         r_boot_cnt <= '0;
         r_to_cnt   <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_BOOT) && (r_boot_cnt != c_BOOT_LAST)) begin
            r_boot_cnt <= r_boot_cnt + 1'b1;
         end
         if ((r_state == S_MEM_WAIT) && !i_dmem_ready) begin
            r_to_cnt <= w_to_nxt;
            if (w_to_nxt == c_TO_MAX) begin
               r_mem_err <= 1'b1;
            end
         end else begin
            r_to_cnt <= '0;
         end
      end
   end

   // Next-state and stall/flush controls from current state and inputs.
   always_comb begin
      w_state_nxt = r_state;
      o_stall_f   = 1'b0;
      o_stall_d   = 1'b0;
      o_stall_e   = 1'b0;
      o_stall_m   = 1'b0;
      o_flush_d   = 1'b0;
      o_flush_e   = 1'b0;
      case (r_state)
         S_BOOT: begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
            if (r_boot_cnt == c_BOOT_LAST) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN, S_MEM_WAIT: begin
            if (w_freeze) begin
               // Freeze everything; a taken branch stays parked in E until release.
               o_stall_f   = 1'b1;
               o_stall_d   = 1'b1;
               o_stall_e   = 1'b1;
               o_stall_m   = 1'b1;
               w_state_nxt = S_MEM_WAIT;
            end else begin
               // The ready cycle of a wait advances the pipeline, so the held
               // branch or load-use hazard is resolved exactly as in RUN.
               w_state_nxt = S_RUN;
               if (i_pcsrc_e) begin
                  o_flush_d = 1'b1;
                  o_flush_e = 1'b1;
               end else if (w_load_use) begin
                  o_stall_f = 1'b1;
                  o_stall_d = 1'b1;
                  o_flush_e = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_BOOT;
         end
      endcase
   end

   // Operand forwarding: memory stage wins over writeback, x0 never forwards.
   always_comb begin
      o_fwd_a_e = 2'b00;
      o_fwd_b_e = 2'b00;
      if (i_regwrite_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs1_e)) begin
         o_fwd_a_e = 2'b10;
      end else if (i_regwrite_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs1_e)) begin
         o_fwd_a_e = 2'b01;
      end
      if (i_regwrite_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs2_e)) begin
         o_fwd_b_e = 2'b10;
      end else if (i_regwrite_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs2_e)) begin
         o_fwd_b_e = 2'b01;
      end
   end

   assign o_mem_err = r_mem_err;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   // Saturating counts of stalled and flushed cycles once boot is over.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (r_state != S_BOOT) begin
         if (o_stall_f && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (o_flush_e && (r_flush_cnt != 32'hFFFF_FFFF)) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
